uart_transmitter: RTL and testbench

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_transmitter.sv | 134 +++++++++++++
 tb/tb_uart_transmitter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// UART transmitter: 8N1-style framing (start bit, DATA_WIDTH data bits LSB first, one stop bit).
// All outputs, including the serial line, come straight from flops.
//
// state | meaning
// IDLE  | line high, counters cleared, waiting for i_start
// START | line low for one bit time
// DATA  | shifting payload out LSB first, one bit time per bit
// STOP  | line high for one bit time, o_done in its final cycle
module uart_transmitter #(
    parameter int CLOCK_COUNTER_WIDTH = 10,
    parameter int BIT_COUNTER_WIDTH   = 3,
    parameter int DATA_WIDTH          = 8,
    parameter int CLOCKS_PER_BIT      = 434
) (
    input  logic                  i_clock,
    input  logic                  i_resetL,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_TX,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam logic [CLOCK_COUNTER_WIDTH-1:0] CLK_LAST = CLOCK_COUNTER_WIDTH'(CLOCKS_PER_BIT - 1);
    localparam logic [BIT_COUNTER_WIDTH-1:0]   BIT_LAST = BIT_COUNTER_WIDTH'(DATA_WIDTH - 1);
    localparam logic [CLOCK_COUNTER_WIDTH-1:0] CLK_ONE  = CLOCK_COUNTER_WIDTH'(1);
    localparam logic [BIT_COUNTER_WIDTH-1:0]   BIT_ONE  = BIT_COUNTER_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                         state_q,   state_d;
    logic [CLOCK_COUNTER_WIDTH-1:0] clk_cnt_q, clk_cnt_d;
    logic [BIT_COUNTER_WIDTH-1:0]   bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0]          shift_q,   shift_d;
    logic                           tx_q,      tx_d;
    logic                           busy_q,    busy_d;
    logic                           done_q,    done_d;
    logic                           bit_end;

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        bit_end   = (clk_cnt_q == CLK_LAST);

        unique case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (i_start) begin
                    shift_d = i_data;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CLK_ONE;
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    shift_d   = shift_q >> 1;
                    // Leave DATA on the last index rather than letting the index wrap.
                    if (bit_idx_q == BIT_LAST) begin
                        bit_idx_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_ONE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CLK_ONE;
                end
            end
            STOP: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + CLK_ONE;
                end
            end
            default: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                state_d   = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register together with it.
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && (clk_cnt_d == CLK_LAST);
    end

    always_ff @(posedge i_clock or negedge i_resetL) begin
        if (!i_resetL) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign o_TX   = tx_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: a scoreboard queue of expected bytes checked cycle by cycle by a
// line monitor on a 4-clock-per-bit instance, plus one default-rate frame on a second instance.
module tb_uart_transmitter;

    logic       clk_sys;
    logic       rst_b;
    logic       start;
    logic [7:0] data;
    logic       tx;
    logic       busy;
    logic       done;
    logic       start_b;
    logic [7:0] data_b;
    logic       tx_b;
    logic       busy_b;
    logic       done_b;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] cur;
    logic       in_frame = 1'b0;
    int         cyc = 0;
    int         frames_done = 0;
    int         aborted = 0;
    int         gap = 0;
    int         last_gap = 0;

    uart_transmitter #(
        .CLOCK_COUNTER_WIDTH(10),
        .BIT_COUNTER_WIDTH  (3),
        .DATA_WIDTH         (8),
        .CLOCKS_PER_BIT     (4)
    ) dut (
        .i_clock (clk_sys),
        .i_resetL(rst_b),
        .i_start (start),
        .i_data  (data),
        .o_TX    (tx),
        .o_busy  (busy),
        .o_done  (done)
    );

    uart_transmitter dut_big (
        .i_clock (clk_sys),
        .i_resetL(rst_b),
        .i_start (start_b),
        .i_data  (data_b),
        .o_TX    (tx_b),
        .o_busy  (busy_b),
        .o_done  (done_b)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Line monitor: a falling line outside a frame starts a frame against the oldest expected byte.
    initial begin
        logic etx;
        forever begin
            @(negedge clk_sys);
            if (rst_b && !in_frame) begin
                if (tx == 1'b0) begin
                    last_gap = gap;
                    if (exp_q.size() == 0) begin
                        check_eq("unexp_frame", 1, 0);
                        cur = 8'h00;
                    end else begin
                        cur = exp_q.pop_front();
                    end
                    in_frame = 1'b1;
                    cyc = 0;
                end else begin
                    gap++;
                    check_eq("idle_busy", {31'b0, busy}, 0);
                    check_eq("idle_done", {31'b0, done}, 0);
                end
            end
            if (in_frame) begin
                if (!rst_b) begin
                    in_frame = 1'b0;
                    aborted++;
                end else begin
                    if (cyc < 4)       etx = 1'b0;
                    else if (cyc < 36) etx = cur[(cyc - 4) / 4];
                    else               etx = 1'b1;
                    check_eq("tx", {31'b0, tx}, {31'b0, etx});
                    check_eq("busy", {31'b0, busy}, 1);
                    check_eq("done", {31'b0, done}, (cyc == 39) ? 1 : 0);
                    cyc++;
                    if (cyc == 40) begin
                        in_frame = 1'b0;
                        frames_done++;
                        gap = 0;
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] d);
        @(posedge clk_sys);
        #1;
        data  = d;
        start = 1'b1;
        exp_q.push_back(d);
        @(posedge clk_sys);
        #1;
        start = 1'b0;
        check_eq("latency", {31'b0, tx}, 0);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (frames_done < n && k < budget) begin
            @(posedge clk_sys);
            k++;
        end
        if (frames_done < n) check_eq("timeout", frames_done, n);
    endtask

    initial begin
        int lo, hi, bz, dn;
        rst_b   = 1'b0;
        start   = 1'b0;
        data    = 8'h00;
        start_b = 1'b0;
        data_b  = 8'h00;
        #25;
        check_eq("rst_tx", {31'b0, tx}, 1);
        check_eq("rst_busy", {31'b0, busy}, 0);
        check_eq("rst_done", {31'b0, done}, 0);
        check_eq("rst_big_tx", {31'b0, tx_b}, 1);
        @(posedge clk_sys);
        #3 rst_b = 1'b1;

        send(8'h55);
        wait_frames(1, 200);

        // Payload change and a second request mid-frame must both be ignored.
        send(8'hA3);
        repeat (9) @(posedge clk_sys);
        #1;
        data  = 8'hFF;
        start = 1'b1;
        @(posedge clk_sys);
        #1;
        start = 1'b0;
        wait_frames(2, 200);

        // Held start: two frames separated by exactly one idle-high cycle.
        @(posedge clk_sys);
        #1;
        data  = 8'h00;
        start = 1'b1;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        wait_frames(3, 200);
        @(posedge clk_sys);
        #1;
        start = 1'b0;
        wait_frames(4, 200);
        check_eq("b2b_gap", last_gap, 1);

        // Asynchronous reset mid-frame, then a request already waiting at reset release.
        send(8'h3C);
        repeat (16) @(posedge clk_sys);
        #2 rst_b = 1'b0;
        #1;
        check_eq("abort_tx", {31'b0, tx}, 1);
        check_eq("abort_busy", {31'b0, busy}, 0);
        check_eq("abort_done", {31'b0, done}, 0);
        data  = 8'h96;
        start = 1'b1;
        exp_q.push_back(8'h96);
        repeat (2) @(posedge clk_sys);
        check_eq("aborted", aborted, 1);
        check_eq("abort_no_done", {31'b0, done}, 0);
        #3 rst_b = 1'b1;
        @(posedge clk_sys);
        #1;
        start = 1'b0;
        check_eq("post_rst_lat", {31'b0, tx}, 0);
        wait_frames(5, 200);

        // Default 434-clock bit time: 0x80 gives 8 bit times low then 2 high.
        @(posedge clk_sys);
        #1;
        data_b  = 8'h80;
        start_b = 1'b1;
        @(posedge clk_sys);
        #1;
        start_b = 1'b0;
        check_eq("big_lat", {31'b0, tx_b}, 0);
        lo = 0; hi = 0; bz = 0; dn = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk_sys);
            if (!busy_b) break;
            bz++;
            if (!tx_b && hi == 0) lo++;
            else                  hi++;
            if (done_b) dn++;
        end
        check_eq("big_low", lo, 3472);
        check_eq("big_high", hi, 868);
        check_eq("big_busy", bz, 4340);
        check_eq("big_done", dn, 1);

        repeat (3) @(posedge clk_sys);
        check_eq("sb_empty", exp_q.size(), 0);
        check_eq("frames", frames_done, 5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
